div_sequencer: RTL and testbench

//  Multi-cycle RISC-V M-extension divider (DIV/DIVU/REM/REMU) built around one shared CLA instance.
//  The FSM time-multiplexes that single adder for operand negation, WIDTH restoring-division

---
 rtl/div_sequencer.sv | 119 +++++++++++
 tb/tb_div_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divider/remainder unit sharing one carry-lookahead subtractor
module cla #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub_en,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] yy, p, gk, pk, gn, pn;
  // Kogge-Stone prefix over generate/propagate with the carry-in folded into bit 0
  always_comb begin
    yy = sub_en ? ~y : y;
    p = x ^ yy;
    gk = x & yy;
    gk[0] = gk[0] | (p[0] & sub_en);
    pk = p;
    gn = gk;
    pn = pk;
    for (int d = 1; d < W; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < W; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    sum = p ^ {gk[W-2:0], sub_en};
    cout = gk[W-1];
  end
endmodule

module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, DIV, FIX, DONE} state_t;
  state_t state, nxt;
  logic [1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, dvs, rem, quo, cx, cy, sum, sel;
  logic [CW-1:0] cnt;
  logic cout, sgn, neg_q, acc, last, ge;
  assign sgn = ~op_q[0];
  assign sel = op_q[1] ? rem : quo;
  assign neg_q = sgn & (op_q[1] ? a_q[WIDTH-1] : a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign acc = inValid & (state == IDLE) & ~flush;
  assign last = cnt == CW'(WIDTH - 1);
  // a set MSB in rem means the shifted partial remainder exceeds 2^WIDTH, so the step always succeeds
  assign ge = cout | rem[WIDTH-1];
  assign inReady = state == IDLE;
  assign busy = state != IDLE;
  assign outValid = state == DONE;
  assign cx = state == DIV ? {rem[WIDTH-2:0], quo[WIDTH-1]} : '0;
  assign cy = state == NEG_A ? a_q : state == NEG_B ? b_q : state == DIV ? dvs : sel;
  cla #(.W(WIDTH)) u_cla (.x(cx), .y(cy), .sub_en(1'b1), .sum(sum), .cout(cout));
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc ? (b == '0 ? DONE : NEG_A) : IDLE;
      NEG_A:   nxt = NEG_B;
      NEG_B:   nxt = DIV;
      DIV:     nxt = last ? FIX : DIV;
      FIX:     nxt = DONE;
      default: nxt = outReady ? IDLE : DONE;
    endcase
    if (flush) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      result <= '0;
    end else if (!flush) begin
      if (acc) begin
        op_q <= op;
        a_q <= a;
        b_q <= b;
        if (b == '0) result <= op[1] ? a : '1;
      end
      if (state == NEG_A) quo <= (sgn & a_q[WIDTH-1]) ? sum : a_q;
      if (state == NEG_B) begin
        dvs <= (sgn & b_q[WIDTH-1]) ? sum : b_q;
        rem <= '0;
        cnt <= '0;
      end
      if (state == DIV) begin
        rem <= ge ? sum : cx;
        quo <= {quo[WIDTH-2:0], ge};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) result <= neg_q ? sum : sel;
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and gold-model checks of the sequential divider
module tb_div_sequencer;
  logic clk = 0, rst_n = 0, flush = 0, inValid = 0, outReady = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic inReady, outValid, busy;
  logic [31:0] result;
  int tests = 0, fails = 0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(inValid), .inReady(inReady),
    .op(op), .a(a), .b(b), .outValid(outValid), .outReady(outReady),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; inValid = 1;
    @(posedge clk);
    #1;
    inValid = 0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit drain, output logic [31:0] r, output int lat, output bit tmo);
    start_op(o, x, y);
    lat = 0;
    tmo = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (outValid) begin
        tmo = 0;
        break;
      end
    end
    r = result;
    if (drain) begin
      outReady = 1;
      @(negedge clk);
      outReady = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] gold(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    if (y == 0) r = o[1] ? x : 32'hFFFFFFFF;
    else if (o == 2'b00) r = (x == 32'h80000000 && y == 32'hFFFFFFFF) ? x : 32'($signed(x) / $signed(y));
    else if (o == 2'b01) r = x / y;
    else if (o == 2'b10) r = (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'h0 : 32'($signed(x) % $signed(y));
    else r = x % y;
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("reset_inReady", {31'b0, inReady}, 32'd1);
    chk("reset_outValid", {31'b0, outValid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_result", result, 32'd0);
  endtask

  task automatic test_unsigned;
    logic [31:0] r; int lat; bit tmo;
    do_op(2'b01, 32'd100, 32'd7, 1, r, lat, tmo);
    chk("divu_100_7", r, 32'd14);
    chk("divu_latency", lat, 32'd36);
    chk("divu_timeout", {31'b0, tmo}, 32'd0);
    do_op(2'b11, 32'd100, 32'd7, 1, r, lat, tmo);
    chk("remu_100_7", r, 32'd2);
    do_op(2'b01, 32'hFFFFFFFF, 32'd1, 1, r, lat, tmo);
    chk("divu_max_1", r, 32'hFFFFFFFF);
    do_op(2'b11, 32'hFFFFFFFF, 32'h80000001, 1, r, lat, tmo);
    chk("remu_big_divisor", r, 32'h7FFFFFFE);
  endtask

  task automatic test_signed;
    logic [31:0] r; int lat; bit tmo;
    do_op(2'b00, -32'd100, 32'd7, 1, r, lat, tmo);
    chk("div_m100_7", r, 32'hFFFFFFF2);
    do_op(2'b10, -32'd100, 32'd7, 1, r, lat, tmo);
    chk("rem_m100_7", r, 32'hFFFFFFFE);
    do_op(2'b10, 32'd100, -32'd7, 1, r, lat, tmo);
    chk("rem_100_m7", r, 32'd2);
    do_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 1, r, lat, tmo);
    chk("div_overflow", r, 32'h80000000);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, r, lat, tmo);
    chk("rem_overflow", r, 32'h0);
  endtask

  task automatic test_div_zero;
    logic [31:0] r; int lat; bit tmo;
    do_op(2'b00, 32'd5, 32'd0, 1, r, lat, tmo);
    chk("div_by0", r, 32'hFFFFFFFF);
    chk("div_by0_latency", lat, 32'd1);
    do_op(2'b01, 32'd5, 32'd0, 1, r, lat, tmo);
    chk("divu_by0", r, 32'hFFFFFFFF);
    do_op(2'b10, 32'd5, 32'd0, 1, r, lat, tmo);
    chk("rem_by0", r, 32'd5);
    do_op(2'b11, 32'd5, 32'd0, 1, r, lat, tmo);
    chk("remu_by0", r, 32'd5);
  endtask

  task automatic test_backpressure;
    logic [31:0] r; int lat; bit tmo; bit bad_v, bad_r, bad_i;
    do_op(2'b01, 32'd1000, 32'd9, 0, r, lat, tmo);
    chk("bp_result", r, 32'd111);
    bad_v = 0; bad_r = 0; bad_i = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (outValid !== 1'b1) bad_v = 1;
      if (result !== 32'd111) bad_r = 1;
      if (inReady !== 1'b0) bad_i = 1;
    end
    chk("bp_outValid_held", {31'b0, bad_v}, 32'd0);
    chk("bp_result_stable", {31'b0, bad_r}, 32'd0);
    chk("bp_inReady_low", {31'b0, bad_i}, 32'd0);
    outReady = 1;
    @(negedge clk);
    outReady = 0;
    chk("bp_drained_inReady", {31'b0, inReady}, 32'd1);
    chk("bp_drained_outValid", {31'b0, outValid}, 32'd0);
    do_op(2'b11, 32'd1000, 32'd9, 1, r, lat, tmo);
    chk("bp_next_op", r, 32'd1);
  endtask

  task automatic test_flush_reset;
    logic [31:0] r; int lat; bit tmo; bit seen;
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (7) @(posedge clk);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_inReady", {31'b0, inReady}, 32'd1);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (outValid) seen = 1;
    end
    chk("flush_no_result", {31'b0, seen}, 32'd0);
    inValid = 1; flush = 1; op = 2'b01; a = 32'd8; b = 32'd2;
    @(negedge clk);
    inValid = 0; flush = 0;
    chk("flush_beats_accept", {31'b0, busy}, 32'd0);
    start_op(2'b00, 32'd77, 32'd5);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midreset_inReady", {31'b0, inReady}, 32'd1);
    chk("midreset_outValid", {31'b0, outValid}, 32'd0);
    chk("midreset_result", result, 32'd0);
    do_op(2'b00, 32'd77, 32'd5, 1, r, lat, tmo);
    chk("after_reset_op", r, 32'd15);
  endtask

  task automatic test_random;
    logic [31:0] r, x, y; int lat; bit tmo;
    for (int o = 0; o < 4; o++)
      for (int k = 0; k < 32; k++) begin
        x = $urandom >> $urandom_range(0, 31);
        y = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) x = -x;
        if ($urandom_range(0, 3) == 0) y = -y;
        do_op(2'(o), x, y, 1, r, lat, tmo);
        chk($sformatf("rand_op%0d_%h_%h", o, x, y), r, gold(2'(o), x, y));
      end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_backpressure();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
